fetch_sequencer: RTL
====================

# fetch_sequencer

Multicycle instruction fetch and sequencing stage that sits directly upstream of the opcode decoder. It owns the program counter, reads instructions from instruction memory through a valid handshake, and holds them in an instruction register. It presents the opcode to the decoder and steps the core through FETCH/DECODE/EXEC, applying jump redirects and halting on HALT.

## Interface
- PC_W, 8: program counter and instruction-memory address width.
- INSTR_W, 16: instruction width; opcode is instr[INSTR_W-1 -: 4].
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_rdata  in  INSTR_W  instruction data, qualified by imem_valid.
- imem_valid  in  1  memory data valid; sampled only in FETCH.
- instr  out  INSTR_W  instruction register contents (operand fields for datapath).
- opcode  out  4  instr[INSTR_W-1 -: 4]; feeds the decoder.
- instr_valid  out  1  high throughout EXEC; qualifies decoder outputs (reg/mem writes).
- exec_ready  in  1  datapath finished current instruction; sampled only in EXEC.
- jump_taken  in  1  redirect request from decoder jump output; sampled only in EXEC with exec_ready.
- jump_target  in  PC_W  redirect address.
- pc  out  PC_W  current program counter.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT. State, pc and ir are registers; all outputs decode from state/registers.
- IDLE: entered on reset. Next cycle goes to FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc. If imem_valid is high, ir<=imem_rdata and go to DECODE. Otherwise stay. Wait is unbounded.
- DECODE: one cycle. opcode is stable so the decoder settles. No outputs asserted. Go to EXEC.
- EXEC: instr_valid=1. Hold until exec_ready=1. On that edge:
  - If opcode==4'b1111 (HALT): pc<=pc+1 and go to HALT. jump_taken is ignored.
  - Else if jump_taken: pc<=jump_target and go to FETCH.
  - Else: pc<=pc+1 and go to FETCH.
- HALT: terminal. halted=1, no requests. pc and ir are frozen. Only rst_n leaves it.
- Opcode 4'b0000 and undefined opcodes are NOPs: sequence normally.
- pc increments modulo 2^PC_W (all-ones wraps to 0). jump_target is used verbatim.
- Inputs outside their sampling state are ignored: imem_valid outside FETCH; exec_ready/jump_taken outside EXEC.

## Timing
- Reset (asynchronous, any state, mid-fetch or mid-exec included) gives: state=IDLE, pc=0, ir=0, imem_req=0, instr_valid=0, halted=0, opcode=0, imem_addr=0. Any in-flight memory response is dropped.
- First imem_req rises one cycle after rst_n deasserts (IDLE→FETCH).
- Minimum instruction period is 3 cycles, with imem_valid and exec_ready already high: FETCH, DECODE, EXEC.
- Each FETCH stall cycle and each EXEC stall cycle adds exactly one cycle.
- ir loads on the edge leaving FETCH. instr/opcode are valid from DECODE onward and unchanged until the next FETCH completes.
- New pc is visible on imem_addr in the first cycle of the following FETCH.
- instr_valid is high for the full EXEC duration. The datapath commits writes only on the edge where instr_valid && exec_ready.

## Test plan
- Reset release, imem_valid tied high, exec_ready tied high, memory holding NOPs: imem_req rises 1 cycle after rst_n. pc goes 0,1,2,… with one increment per 3 cycles. instr_valid pulses 1 cycle every 3.
- Fetch stall: hold imem_valid low 4 cycles at pc=5 → imem_req stays high with imem_addr=5 for 5 cycles. ir loads only on the valid edge. A valid pulse during EXEC is ignored.
- Jump: instruction 16'hA000 with jump_taken=1, jump_target=8'h40, exec_ready delayed 2 cycles → instr_valid is high 3 cycles. Next fetch address is 0x40.
- HALT: fetch 16'hF000 at pc=0x12, with jump_taken=1 asserted → halted=1 and pc=0x13. No further imem_req for 20 cycles.
- Wrap: pc=0xFF executing a NOP → next imem_addr=0x00.
- Async reset mid-EXEC with instr_valid high: outputs go to reset values immediately, without a clock edge. Fetch restarts at address 0 one cycle after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns pc and the instruction register, steps FETCH/DECODE/EXEC, applies jump redirects, parks in HALT.
// Latency: 3 cycles per instruction minimum; each imem_valid-low FETCH cycle or exec_ready-low EXEC cycle adds one.
// Backpressure: FETCH waits unbounded on imem_valid, EXEC waits unbounded on exec_ready; HALT is left only by rst_n.
module fetch_sequencer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic               instr_valid,
    input  logic               exec_ready,
    input  logic               jump_taken,
    input  logic [PC_W-1:0]    jump_target,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               imem_req_q;
    logic               instr_valid_q;
    logic               halted_q;

    logic [PC_W-1:0]    pc_seq_d;
    logic [3:0]         op_d;

    // Sequential pc wraps naturally at the register width.
    assign pc_seq_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign op_d     = ir_q[INSTR_W-1 -: 4];

    // Outputs are registered alongside state so each one is a flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_q       <= imem_rdata;
                        state_q    <= S_DECODE;
                        imem_req_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    state_q       <= S_EXEC;
                    instr_valid_q <= 1'b1;
                end
                S_EXEC: begin
                    if (exec_ready) begin
                        instr_valid_q <= 1'b0;
                        // HALT wins over any redirect presented in the same cycle.
                        if (op_d == OP_HALT) begin
                            pc_q     <= pc_seq_d;
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q       <= jump_taken ? jump_target : pc_seq_d;
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q       <= S_IDLE;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign opcode      = op_d;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule
